// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch-stage PC controller.
//   fetch_state_e      : controller state encoding (BOOT=0, RUN=1, HALTED=2)
//   DefaultResetVector : PC loaded by reset unless overridden
//   DefaultTrapVector  : PC loaded on trap entry unless overridden
package fetch_pkg;

    typedef enum logic [1:0] {
        StBoot   = 2'd0,
        StRun    = 2'd1,
        StHalted = 2'd2
    } fetch_state_e;

    localparam logic [31:0] DefaultResetVector = 32'h0000_0000;
    localparam logic [31:0] DefaultTrapVector  = 32'h0000_0080;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux for the fetch PC controller.
// Applies the RUN-state update rules (trap, eret, redirect, halt, advance)
// and reports when the FSM must move to HALTED.
//   run_i          : controller is in RUN; otherwise all state holds
//   fetch_valid_i  : current PC is being offered to instruction memory
//   fetch_ready_i  : instruction memory accepts the current PC
//   trap_i/eret_i  : exception request / return from trap
//   redirect_i     : load target_i (traps if target_i is misaligned)
//   halt_i         : request halt
//   pc_i/epc_i     : current PC / saved trap PC
//   in_trap_i      : trap handler active
//   misaligned_i   : sticky misaligned-redirect flag
//   pc_o/epc_o/in_trap_o/misaligned_o : next values of the above
//   halt_o         : move to HALTED (halt request or double fault)
module pc_next_sel
    import fetch_pkg::*;
#(
    parameter int unsigned        WIDTH       = 32,
    parameter logic [WIDTH-1:0]   TRAP_VECTOR = WIDTH'(DefaultTrapVector),
    parameter int unsigned        INC         = 4,
    parameter int unsigned        ALIGN_BITS  = 2
) (
    input  logic               run_i,
    input  logic               fetch_valid_i,
    input  logic               fetch_ready_i,
    input  logic               trap_i,
    input  logic               eret_i,
    input  logic               redirect_i,
    input  logic               halt_i,
    input  logic [WIDTH-1:0]   target_i,
    input  logic [WIDTH-1:0]   pc_i,
    input  logic [WIDTH-1:0]   epc_i,
    input  logic               in_trap_i,
    input  logic               misaligned_i,
    output logic [WIDTH-1:0]   pc_o,
    output logic [WIDTH-1:0]   epc_o,
    output logic               in_trap_o,
    output logic               misaligned_o,
    output logic               halt_o
);

    // Mask of low bits that must be zero; an all-zero mask disables the check.
    localparam logic [WIDTH-1:0] AlignMask = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    logic target_misaligned;
    logic take_trap;

    assign target_misaligned = |(target_i & AlignMask);

    always_comb begin
        pc_o         = pc_i;
        epc_o        = epc_i;
        in_trap_o    = in_trap_i;
        misaligned_o = misaligned_i;
        halt_o       = 1'b0;
        take_trap    = 1'b0;

        if (run_i) begin
            if (trap_i) begin
                take_trap = 1'b1;
            end else if (eret_i && in_trap_i) begin
                pc_o         = epc_i;
                in_trap_o    = 1'b0;
                misaligned_o = 1'b0;
            end else if (redirect_i) begin
                if (target_misaligned) begin
                    take_trap    = 1'b1;
                    misaligned_o = 1'b1;
                end else begin
                    pc_o = target_i;
                end
            end else if (halt_i) begin
                halt_o = 1'b1;
            end else if (fetch_valid_i && fetch_ready_i) begin
                pc_o = pc_i + WIDTH'(INC);
            end

            // A trap raised while already in the handler is a double fault:
            // freeze everything and halt instead of re-entering.
            if (take_trap) begin
                if (in_trap_i) begin
                    halt_o = 1'b1;
                end else begin
                    epc_o     = pc_i;
                    pc_o      = TRAP_VECTOR;
                    in_trap_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage program-counter controller. Holds the fetch PC, offers it to
// instruction memory with a valid/ready handshake and sequences BOOT/RUN/HALTED.
//   Clock          : rising-edge clock
//   Reset          : asynchronous active-high reset
//   Stall          : hold PC and suppress FetchValid
//   Redirect       : load RedirectTarget (branch/jump)
//   RedirectTarget : redirect address
//   Trap / Eret    : exception entry / return
//   Halt / Resume  : enter / leave HALTED
//   FetchReady     : instruction memory accepts PC
//   PC             : registered fetch address
//   FetchValid     : PC is a valid fetch request
//   EPC            : registered PC saved at trap entry
//   InTrap         : trap handler active
//   Misaligned     : last trap came from a misaligned redirect (sticky)
//   State          : BOOT=0, RUN=1, HALTED=2
module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int unsigned        WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = WIDTH'(DefaultResetVector),
    parameter logic [WIDTH-1:0]   TRAP_VECTOR  = WIDTH'(DefaultTrapVector),
    parameter int unsigned        INC          = 4,
    parameter int unsigned        ALIGN_BITS   = 2
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Stall,
    input  logic               Redirect,
    input  logic [WIDTH-1:0]   RedirectTarget,
    input  logic               Trap,
    input  logic               Eret,
    input  logic               Halt,
    input  logic               Resume,
    input  logic               FetchReady,
    output logic [WIDTH-1:0]   PC,
    output logic               FetchValid,
    output logic [WIDTH-1:0]   EPC,
    output logic               InTrap,
    output logic               Misaligned,
    output logic [1:0]         State
);

    fetch_state_e     state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             in_trap_q, in_trap_d;
    logic             misaligned_q, misaligned_d;
    logic             halt_req;
    logic             run;

    assign run        = (state_q == StRun);
    assign FetchValid = run && !Stall;

    pc_next_sel #(
        .WIDTH       (WIDTH),
        .TRAP_VECTOR (TRAP_VECTOR),
        .INC         (INC),
        .ALIGN_BITS  (ALIGN_BITS)
    ) u_pc_next_sel (
        .run_i         (run),
        .fetch_valid_i (FetchValid),
        .fetch_ready_i (FetchReady),
        .trap_i        (Trap),
        .eret_i        (Eret),
        .redirect_i    (Redirect),
        .halt_i        (Halt),
        .target_i      (RedirectTarget),
        .pc_i          (pc_q),
        .epc_i         (epc_q),
        .in_trap_i     (in_trap_q),
        .misaligned_i  (misaligned_q),
        .pc_o          (pc_d),
        .epc_o         (epc_d),
        .in_trap_o     (in_trap_d),
        .misaligned_o  (misaligned_d),
        .halt_o        (halt_req)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:   state_d = StRun;
            StRun:    if (halt_req) state_d = StHalted;
            StHalted: if (Resume) state_d = StRun;
            default:  state_d = StBoot;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= StBoot;
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            in_trap_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            in_trap_q    <= in_trap_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign PC         = pc_q;
    assign EPC        = epc_q;
    assign InTrap     = in_trap_q;
    assign Misaligned = misaligned_q;
    assign State      = state_q;

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Parametrised program-counter controller for the fetch stage. Holds the current fetch address and drives it to instruction memory with a valid/ready handshake. Selects the next PC from sequential increment, redirect (branch/jump), trap entry or trap return, and supports stall, halt/resume, misaligned-target trapping and double-fault halting. It replaces the bare PC register between the next-PC logic and the instruction memory.

## Interface
- WIDTH, 32, address width in bits
- RESET_VECTOR, 32'h00000000, PC value loaded by reset
- TRAP_VECTOR, 32'h00000080, PC value loaded on trap entry
- INC, 4, sequential increment in bytes
- ALIGN_BITS, 2, low PC bits that must be zero; 0 disables the alignment check
- Clock  in  1  sole clock, rising edge
- Reset  in  1  asynchronous, active-high; all state is cleared immediately
- Stall  in  1  hold PC, suppress FetchValid
- Redirect  in  1  load RedirectTarget
- RedirectTarget  in  WIDTH  branch/jump target
- Trap  in  1  exception request
- Eret  in  1  return from trap
- Halt  in  1  request halt
- Resume  in  1  leave halt
- FetchReady  in  1  instruction memory accepts the current PC
- PC  out  WIDTH  current fetch address, registered
- FetchValid  out  1  PC is a valid fetch request
- EPC  out  WIDTH  PC saved at trap entry, registered
- InTrap  out  1  trap handler active
- Misaligned  out  1  sticky flag: last trap was caused by a misaligned redirect
- State  out  2  BOOT=0, RUN=1, HALTED=2

## Operation
- States:
  - BOOT: entered on reset. Moves to RUN unconditionally at the next edge. All control inputs are ignored.
  - RUN: normal fetch.
  - HALTED: PC and EPC frozen. Only Resume is honoured; it moves the block to RUN.
- RUN update priority, highest first:
  1. Trap. If InTrap=0: EPC<=PC, PC<=TRAP_VECTOR, InTrap<=1. If InTrap=1 (double fault): State<=HALTED, PC unchanged.
  2. Eret with InTrap=1: PC<=EPC, InTrap<=0, Misaligned<=0. Eret with InTrap=0 is ignored and falls through to the next rule.
  3. Redirect:
     - RedirectTarget[ALIGN_BITS-1:0]==0: PC<=RedirectTarget.
     - Otherwise, handled as Trap (same double-fault rule) and Misaligned<=1.
  4. Halt: State<=HALTED, PC unchanged.
  5. FetchValid && FetchReady: PC<=PC+INC, truncated to WIDTH (wraps from all-ones to low values).
  6. Otherwise PC holds.
- Stall does not block rules 1–4. It only blocks rule 5, because FetchValid=0 while stalled.
- FetchValid = (State==RUN) && !Stall. It is combinational from registered state and Stall.
- Once FetchValid is asserted, PC stays stable until the handshake completes or a higher-priority event occurs.

## Timing
- Reset values: PC=RESET_VECTOR, EPC=0, InTrap=0, Misaligned=0, State=BOOT, FetchValid=0.
- The first fetch request is one cycle after reset deassertion, when State=RUN.
- Redirect, Trap and Eret take effect at the next rising edge; the new PC is visible in the following cycle. No extra bubble is inserted.
- Sequential advance: one PC per cycle when FetchReady is held high.
- Reset asserted mid-operation clears all state asynchronously in the same cycle, including HALTED and InTrap.
- Simultaneous Trap and Redirect: Trap wins and the redirect is dropped.
- Simultaneous Halt and Redirect: the redirect is taken; Halt must be re-asserted.

## Structure
- Shared package `fetch_pkg`: the state encoding constants (BOOT/RUN/HALTED) and the default reset and trap vectors.
- One combinational sub-module, `pc_next_sel`: priority mux producing next PC, next EPC and flag updates. The top level holds the registers and the FSM.

## Test plan
- Reset, then FetchReady=1 for 4 cycles → PC 0x0, 0x4, 0x8, 0xC; FetchValid=0 during BOOT.
- Stall=1 for 3 cycles at PC=0x10 → PC holds 0x10 and FetchValid=0; after release, PC advances to 0x14.
- Redirect to 0x200 → PC=0x200 next cycle. Redirect to 0x202 at PC=0x40 → PC=0x80, EPC=0x40, Misaligned=1, InTrap=1.
- Trap at PC=0x100, then Eret → PC=0x80, EPC=0x100, then PC=0x100, InTrap=0. A second Trap while InTrap=1 → State=HALTED, PC frozen.
- Halt → FetchValid=0 and PC holds; Resume → RUN and fetch continues. Asserting Reset mid-HALTED → State=BOOT, PC=RESET_VECTOR.
- WIDTH=8, RESET_VECTOR=8'hF8, FetchReady=1 → PC F8, FC, 00, 04 (wrap-around).
